// File: rtl/drive_pkg.sv
// Shared definitions for the drive command path.
// Contents: 3-bit command codes, 7-bit one-hot direction encodings
// (identical to the motor stage), command FSM state type, and helpers for
// code-to-one-hot decode and forward/reverse family classification.
package drive_pkg;

  typedef enum logic [2:0] {
    CMD_FWD   = 3'd0,
    CMD_IDLE  = 3'd1,
    CMD_BWD   = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_ACC   = 3'd5,
    CMD_DEC   = 3'd6,
    CMD_RSVD  = 3'd7
  } cmd_t;

  localparam logic [6:0] DIR_FORWARD  = 7'b0000001;
  localparam logic [6:0] DIR_IDLE     = 7'b0000010;
  localparam logic [6:0] DIR_BACKWARD = 7'b0000100;
  localparam logic [6:0] DIR_LEFT     = 7'b0001000;
  localparam logic [6:0] DIR_RIGHT    = 7'b0010000;
  localparam logic [6:0] DIR_ACC      = 7'b0100000;
  localparam logic [6:0] DIR_DEC      = 7'b1000000;

  typedef enum logic {
    ST_RUN,
    ST_DEAD
  } state_t;

  // Reserved code 7 falls through to IDLE.
  function automatic logic [6:0] code_to_onehot(input logic [2:0] code);
    logic [6:0] dir;
    case (cmd_t'(code))
      CMD_FWD:   dir = DIR_FORWARD;
      CMD_BWD:   dir = DIR_BACKWARD;
      CMD_LEFT:  dir = DIR_LEFT;
      CMD_RIGHT: dir = DIR_RIGHT;
      CMD_ACC:   dir = DIR_ACC;
      CMD_DEC:   dir = DIR_DEC;
      default:   dir = DIR_IDLE;
    endcase
    return dir;
  endfunction

  function automatic logic is_fwd_family(input logic [6:0] dir);
    return (dir == DIR_FORWARD) || (dir == DIR_ACC);
  endfunction

  function automatic logic is_rev_family(input logic [6:0] dir);
    return (dir == DIR_BACKWARD) || (dir == DIR_DEC);
  endfunction

  function automatic logic is_ramp_dir(input logic [6:0] dir);
    return (dir == DIR_ACC) || (dir == DIR_DEC);
  endfunction

  function automatic logic families_opposite(input logic [6:0] cur, input logic [6:0] nxt);
    return (is_fwd_family(cur) && is_rev_family(nxt)) ||
           (is_rev_family(cur) && is_fwd_family(nxt));
  endfunction

endpackage

// File: rtl/drive_cmd_ctrl_pwm_ramp_gen.sv
// pwm_ramp_gen: free-running PWM period counter with a ramped duty cycle.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   enable      ramp PWM active (direction being registered is ACC/DEC)
//   restart     first cycle of a new ACC/DEC episode
//   pwm         registered PWM output
// Duty starts at DUTY_START, rises by DUTY_STEP every RAMP_CYCLES enabled
// cycles and saturates at PWM_PERIOD (output constantly high).
module pwm_ramp_gen
  import drive_pkg::*;
#(
  parameter int unsigned PWM_PERIOD  = 1250,
  parameter int unsigned DUTY_START  = 250,
  parameter int unsigned DUTY_STEP   = 25,
  parameter int unsigned RAMP_CYCLES = 1250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic pwm
);

  localparam int unsigned W  = $clog2(PWM_PERIOD + 1);
  localparam int unsigned RW = $clog2(RAMP_CYCLES + 1);

  localparam logic [W-1:0]  PERIOD_W  = W'(PWM_PERIOD);
  localparam logic [W-1:0]  CNT_LAST  = W'(PWM_PERIOD - 1);
  localparam logic [W-1:0]  START_W   = W'(DUTY_START);
  localparam logic [W-1:0]  STEP_W    = W'(DUTY_STEP);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);

  logic [W-1:0]  cnt;
  logic [W-1:0]  duty;
  logic [W-1:0]  headroom;
  logic [RW-1:0] timer;

  // duty never exceeds PWM_PERIOD, so this cannot underflow; testing the
  // headroom first keeps duty + DUTY_STEP inside W bits.
  assign headroom = PERIOD_W - duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      duty  <= START_W;
      timer <= '0;
      pwm   <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + W'(1);
      pwm <= enable && (cnt < (restart ? START_W : duty));
      if (restart || !enable) begin
        duty  <= START_W;
        timer <= '0;
      end else if (timer == RAMP_LAST) begin
        timer <= '0;
        duty  <= (32'(headroom) <= DUTY_STEP) ? PERIOD_W : duty + STEP_W;
      end else begin
        timer <= timer + RW'(1);
      end
    end
  end

endmodule

// File: rtl/drive_cmd_ctrl.sv
// drive_cmd_ctrl: command stage for the dual-motor H-bridge driver.
// Ports:
//   clk_125mhz, reset_n  clock / asynchronous active-low reset
//   cmd_valid, cmd_code  command handshake input (3-bit code)
//   cmd_ready            high when a command can be accepted
//   direction            registered 7-bit one-hot drive state
//   pwm_signal           ramped PWM, only active in ACC/DEC
//   wdog_trip            one-cycle pulse on command-silence timeout
// Optional feature macro: CMD_WATCHDOG_EN (command-silence watchdog; when
// undefined wdog_trip is tied low and no counter exists).
// A forward<->reverse reversal forces IDLE for DEAD_CYCLES cycles before the
// pending command is applied.
module drive_cmd_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned PWM_PERIOD  = 1250,
  parameter int unsigned DUTY_START  = 250,
  parameter int unsigned DUTY_STEP   = 25,
  parameter int unsigned RAMP_CYCLES = 1250000,
  parameter int unsigned DEAD_CYCLES = 125000,
  parameter int unsigned WDOG_CYCLES = 62500000
) (
  input  logic       clk_125mhz,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic [6:0] direction,
  output logic       pwm_signal,
  output logic       wdog_trip
);

  if (DUTY_START > PWM_PERIOD || DEAD_CYCLES == 0 || WDOG_CYCLES == 0) begin : g_bad_params
    $error("drive_cmd_ctrl: invalid parameter set");
  end

  localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

  state_t        state, state_n;
  logic [6:0]    cmd_dir, dir_n, pending, pending_n;
  logic [DW-1:0] dead_cnt, dead_n;
  logic          accept;
  logic          ramp_en, ramp_restart;

`ifdef CMD_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_FULL = WW'(WDOG_CYCLES);
  logic [WW-1:0] wdog_cnt, wdog_n;
  logic          trip_n;
`endif

  assign accept  = cmd_valid && cmd_ready;
  assign cmd_dir = code_to_onehot(cmd_code);

  always_comb begin
    state_n   = state;
    dir_n     = direction;
    pending_n = pending;
    dead_n    = dead_cnt;
    case (state)
      ST_RUN: begin
        if (accept) begin
          if (families_opposite(direction, cmd_dir)) begin
            dir_n     = DIR_IDLE;
            pending_n = cmd_dir;
            dead_n    = '0;
            state_n   = ST_DEAD;
          end else begin
            dir_n = cmd_dir;
          end
        end
      end
      ST_DEAD: begin
        if (dead_cnt == DEAD_LAST) begin
          dir_n     = pending;
          pending_n = DIR_IDLE;
          dead_n    = '0;
          state_n   = ST_RUN;
        end else begin
          dead_n = dead_cnt + DW'(1);
        end
      end
    endcase
`ifdef CMD_WATCHDOG_EN
    wdog_n = wdog_cnt;
    trip_n = 1'b0;
    if (accept) begin
      wdog_n = '0;
    end else if (wdog_cnt == WDOG_LAST) begin
      wdog_n    = WDOG_FULL;
      trip_n    = 1'b1;
      dir_n     = DIR_IDLE;
      pending_n = DIR_IDLE;
      dead_n    = '0;
      state_n   = ST_RUN;
    end else if (wdog_cnt != WDOG_FULL) begin
      wdog_n = wdog_cnt + WW'(1);
    end
`endif
  end

  always_ff @(posedge clk_125mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      direction <= DIR_IDLE;
      pending   <= DIR_IDLE;
      dead_cnt  <= '0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_n;
      direction <= dir_n;
      pending   <= pending_n;
      dead_cnt  <= dead_n;
      cmd_ready <= (state_n == ST_RUN);
    end
  end

`ifdef CMD_WATCHDOG_EN
  always_ff @(posedge clk_125mhz or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else begin
      wdog_cnt  <= wdog_n;
      wdog_trip <= trip_n;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

  // The ramp generator is driven from the direction being registered so that
  // pwm_signal switches in the same cycle as direction.
  assign ramp_en      = is_ramp_dir(dir_n);
  assign ramp_restart = ramp_en && (dir_n != direction);

  pwm_ramp_gen #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_START (DUTY_START),
    .DUTY_STEP  (DUTY_STEP),
    .RAMP_CYCLES(RAMP_CYCLES)
  ) u_pwm (
    .clk    (clk_125mhz),
    .rst_n  (reset_n),
    .enable (ramp_en),
    .restart(ramp_restart),
    .pwm    (pwm_signal)
  );

endmodule
